// File: rtl/option_feeder.sv
// option_feeder -- streams candidate options for each board line to a solver.
//
// Purpose:
//   Keeps a circular queue of line indices (rows 0..SIZE-1, columns
//   SIZE..2*SIZE-1). For each popped line with a non-zero option count it
//   emits the line index word, followed by that line's options read from an
//   external option memory. Gaps only appear between lines. After each line
//   the solver may ask for the line to be requeued, and streaming stops once
//   the solver reports the board solved or the queue drains.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse; begins a solve from IDLE or DONE
//   options_amnt      live remaining-option count per line (solver owned)
//   opt_addr          option memory read address (line*MAX_OPTS + k)
//   opt_rdata         option memory data, valid one cycle after opt_addr
//   option, valid_op  stream word (line index or option pattern) + qualifier
//   started           high from the first emitted word until DONE
//   put_back_to_FIFO  requeue request, sampled only in the cycle after a line
//   solved            solver reports board complete (honoured between lines)
//   done              high in DONE
//   stuck             requeue limit reached (optional feature)
//
// Optional feature (macro FEEDER_PASS_LIMIT_EN):
//   When defined, an 8-bit requeue counter ends the solve with stuck=1 once
//   MAX_REQUEUE pushes have been made since start. When undefined, requeueing
//   is unbounded and stuck is tied low.
module option_feeder #(
  parameter int         SIZE        = 3,
  parameter int         MAX_OPTS    = 64,
  parameter logic [7:0] MAX_REQUEUE = 8'd255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [6:0]                           options_amnt [2*SIZE],
  output logic [$clog2(2*SIZE*MAX_OPTS)-1:0]   opt_addr,
  input  logic [SIZE-1:0]                      opt_rdata,
  output logic [SIZE-1:0]                      option,
  output logic                                 valid_op,
  output logic                                 started,
  input  logic                                 put_back_to_FIFO,
  input  logic                                 solved,
  output logic                                 done,
  output logic                                 stuck
);

  localparam int LINES = 2*SIZE;
  localparam int AW    = $clog2(2*SIZE*MAX_OPTS);
  localparam int PW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW    = $clog2(LINES+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_POP, S_IDX, S_OPT, S_WAIT, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [SIZE-1:0] queue_mem [LINES];
  logic [PW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic [SIZE-1:0] load_reg;     // next line index pushed during LOAD
  logic [SIZE-1:0] line_reg;     // line currently being streamed
  logic [6:0]      cnt_reg;      // option count latched at pop time
  logic [6:0]      k_reg;        // index of the option word currently out
  logic            started_reg;

  logic [SIZE-1:0] head_line;
  logic [6:0]      head_cnt;
  logic            last_opt;
  logic            push_back;
  logic            push_en;
  logic [SIZE-1:0] push_data;
  logic            start_ok;
  logic            limit_hit;
  logic [AW-1:0]   base_addr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(LINES-1)) ? '0 : p + 1'b1;
  endfunction

  assign head_line = queue_mem[head_reg];
  assign head_cnt  = options_amnt[head_line];
  assign last_opt  = (k_reg == cnt_reg - 7'd1);
  assign push_back = (state_reg == S_WAIT) && put_back_to_FIFO;
  assign push_en   = (state_reg == S_LOAD) || push_back;
  assign push_data = (state_reg == S_LOAD) ? load_reg : line_reg;
  assign start_ok  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign base_addr = AW'(line_reg) * AW'(MAX_OPTS);

`ifdef FEEDER_PASS_LIMIT_EN
  logic [7:0] rq_reg;
  logic       stuck_reg;

  assign limit_hit = push_back && ((rq_reg + 8'd1) == MAX_REQUEUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_reg    <= '0;
      stuck_reg <= 1'b0;
    end else if (start_ok) begin
      rq_reg    <= '0;
      stuck_reg <= 1'b0;
    end else begin
      if (push_back) rq_reg <= rq_reg + 8'd1;
      if (limit_hit) stuck_reg <= 1'b1;
    end
  end

  assign stuck = stuck_reg;
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_REQUEUE;
  assign limit_hit  = 1'b0;
  assign stuck      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_LOAD;
      S_LOAD:         if (load_reg == SIZE'(LINES-1)) state_next = S_POP;
      S_POP: begin
        // A zero-count line is dropped and POP repeats with the next head.
        if (solved || (count_reg == '0)) state_next = S_DONE;
        else if (head_cnt != 7'd0)       state_next = S_IDX;
      end
      S_IDX:          state_next = S_OPT;
      S_OPT:          if (last_opt) state_next = S_WAIT;
      S_WAIT:         state_next = limit_hit ? S_DONE : S_POP;
      default:        state_next = S_IDLE;
    endcase
  end

  // Outputs. The address runs one word ahead of the stream so that the
  // memory's one-cycle read latency lines up with consecutive option words.
  always_comb begin
    valid_op = 1'b0;
    option   = '0;
    opt_addr = '0;
    case (state_reg)
      S_IDX: begin
        valid_op = 1'b1;
        option   = line_reg;
        opt_addr = base_addr;
      end
      S_OPT: begin
        valid_op = 1'b1;
        option   = opt_rdata;
        if (({1'b0, k_reg} + 8'd1) < {1'b0, cnt_reg})
          opt_addr = base_addr + AW'(k_reg) + AW'(1);
      end
      default: ;
    endcase
  end

  assign done    = (state_reg == S_DONE);
  assign started = started_reg || (state_reg == S_IDX);

  // Queue storage: plain array, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push_en) queue_mem[tail_reg] <= push_data;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      load_reg    <= '0;
      line_reg    <= '0;
      cnt_reg     <= '0;
      k_reg       <= '0;
      started_reg <= 1'b0;
    end else begin
      if (start_ok) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        load_reg  <= '0;
      end else begin
        if (push_en) begin
          tail_reg  <= wrap_inc(tail_reg);
          count_reg <= count_reg + 1'b1;
        end
        if (state_reg == S_LOAD) load_reg <= load_reg + 1'b1;
        if ((state_reg == S_POP) && !solved && (count_reg != '0)) begin
          head_reg  <= wrap_inc(head_reg);
          count_reg <= count_reg - 1'b1;
          line_reg  <= head_line;
          cnt_reg   <= head_cnt;
        end
      end
      if (state_reg == S_IDX)      k_reg <= '0;
      else if (state_reg == S_OPT) k_reg <= k_reg + 7'd1;
      if (state_next == S_DONE)     started_reg <= 1'b0;
      else if (state_reg == S_IDX)  started_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_option_feeder.sv
module tb_option_feeder;
  localparam int SIZE     = 3;
  localparam int MAX_OPTS = 64;
  localparam int LINES    = 2*SIZE;
  localparam int AW       = $clog2(2*SIZE*MAX_OPTS);
`ifdef FEEDER_PASS_LIMIT_EN
  localparam int LIMIT = 4;
`else
  localparam int LIMIT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            put_back = 1'b0;
  logic            solved = 1'b0;
  logic [6:0]      amnt [LINES];
  logic [AW-1:0]   opt_addr;
  logic [SIZE-1:0] opt_rdata = '0;
  logic [SIZE-1:0] option;
  logic            valid_op, started, done, stuck;
  logic [SIZE-1:0] mem [2*SIZE*MAX_OPTS];

  always #5 clk = ~clk;
  always @(posedge clk) opt_rdata <= mem[opt_addr];

  option_feeder #(.SIZE(SIZE), .MAX_OPTS(MAX_OPTS), .MAX_REQUEUE(8'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .options_amnt(amnt),
    .opt_addr(opt_addr), .opt_rdata(opt_rdata), .option(option),
    .valid_op(valid_op), .started(started), .put_back_to_FIFO(put_back),
    .solved(solved), .done(done), .stuck(stuck)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model inputs and expected stream
  bit dec [32];       // requeue decision for the n-th streamed line
  int solve_line;     // solved raised while streaming this line (-1: never)
  int exp_word[$];
  bit exp_idx[$];
  int exp_gap[$];     // idle cycles expected before an index word (-1: unchecked)
  bit exp_stuck;
  int obs[$];

  function automatic void build_model();
    int q[$];
    int l, n, rq, drops;
    bit first;
    n = 0; rq = 0; drops = 0; first = 1; exp_stuck = 0;
    exp_word.delete(); exp_idx.delete(); exp_gap.delete();
    for (int i = 0; i < LINES; i++) q.push_back(i);
    while (q.size() > 0) begin
      l = q.pop_front();
      if (amnt[l] == 0) begin
        drops++;
        continue;
      end
      exp_word.push_back(l); exp_idx.push_back(1);
      exp_gap.push_back(first ? -1 : 2 + drops);
      first = 0; drops = 0;
      for (int k = 0; k < int'(amnt[l]); k++) begin
        exp_word.push_back(int'(mem[l*MAX_OPTS + k]));
        exp_idx.push_back(0); exp_gap.push_back(-1);
      end
      if (l == solve_line) break;
      if ((n < 32) && dec[n]) begin
        q.push_back(l);
        rq++;
        if ((LIMIT != 0) && (rq == LIMIT)) begin
          exp_stuck = 1;
          break;
        end
      end
      n++;
    end
  endfunction

  task automatic run(input string name, input int abort_after, input bit poke_start);
    int pos, gap, n, cur;
    bit solved_set;
    pos = 0; gap = 0; n = 0; cur = -1; solved_set = 0;
    obs.delete();
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid_op) begin
        obs.push_back(int'(option));
        if (pos < exp_word.size()) begin
          check({name, "/word"}, option, exp_word[pos]);
          check({name, "/started"}, started, 1);
          if (exp_idx[pos]) begin
            cur = exp_word[pos];
            if (exp_gap[pos] >= 0) check({name, "/gap"}, gap, exp_gap[pos]);
            put_back = (n < 32) ? dec[n] : 1'b0;
            n++;
            if (poke_start) start = 1'b1;  // must be ignored mid-stream
          end else if ((cur == solve_line) && !solved_set) begin
            solved = 1'b1;
            solved_set = 1;
          end
        end else begin
          check({name, "/extra"}, valid_op, 0);
        end
        pos++;
        gap = 0;
        if ((abort_after > 0) && (pos == abort_after)) return;
      end else begin
        gap++;
      end
      if (done) break;
    end
    check({name, "/len"}, pos, exp_word.size());
    check({name, "/done"}, done, 1);
    check({name, "/stuck"}, stuck, exp_stuck);
    check({name, "/started_end"}, started, 0);
    check({name, "/valid_end"}, valid_op, 0);
    $display("%s: %0d words, stuck=%0d", name, pos, stuck);
    solved = 1'b0;
    put_back = 1'b0;
  endtask

  task automatic setup_directed();
    int cnts [LINES];
    cnts = '{2, 3, 1, 1, 2, 3};
    for (int l = 0; l < LINES; l++) begin
      amnt[l] = 7'(cnts[l]);
      for (int k = 0; k < 8; k++) mem[l*MAX_OPTS + k] = SIZE'($urandom);
    end
    mem[0] = 3'b110;
    mem[1] = 3'b011;
    for (int i = 0; i < 32; i++) dec[i] = 0;
    solve_line = -1;
  endtask

  task automatic setup_random();
    for (int l = 0; l < LINES; l++) begin
      amnt[l] = 7'($urandom_range(0, 4));
      for (int k = 0; k < 8; k++) mem[l*MAX_OPTS + k] = SIZE'($urandom);
    end
    for (int i = 0; i < 32; i++) dec[i] = (i < 12) && ($urandom_range(0, 2) == 0);
    solve_line = -1;
  endtask

  initial begin
    for (int i = 0; i < 2*SIZE*MAX_OPTS; i++) mem[i] = '0;
    for (int l = 0; l < LINES; l++) amnt[l] = '0;
    repeat (2) @(negedge clk);
    check("rst/valid", valid_op, 0);
    check("rst/done", done, 0);
    check("rst/started", started, 0);
    check("rst/stuck", stuck, 0);
    check("rst/addr", opt_addr, 0);
    check("rst/option", option, 0);
    rst = 1'b0;

    setup_directed();
    run("basic", 0, 0);
    check("basic/w0", obs[0], 0);
    check("basic/w1", obs[1], 3'b110);
    check("basic/w2", obs[2], 3'b011);

    setup_directed();
    dec[0] = 1;
    run("requeue0", 0, 0);

    setup_directed();
    amnt[2] = 7'd0;
    run("skip2", 0, 0);

    setup_directed();
    solve_line = 4;
    run("solved4", 0, 0);

    setup_directed();
    run("abort", 5, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort/valid", valid_op, 0);
    check("abort/started", started, 0);
    check("abort/done", done, 0);
    check("abort/addr", opt_addr, 0);
    rst = 1'b0;
    put_back = 1'b0;
    run("replay", 0, 0);
    check("replay/w0", obs[0], 0);

`ifdef FEEDER_PASS_LIMIT_EN
    setup_directed();
    for (int i = 0; i < 32; i++) dec[i] = 1;
    run("limit", 0, 0);
`endif

    for (int t = 0; t < 8; t++) begin
      setup_random();
      run($sformatf("rand%0d", t), 0, (t % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
